// File: rtl/ads41_cal_pkg.sv
// ads41_cal_pkg: shared FSM states, tap width and step-direction constants for the ADS41 IDELAY calibrator
package ads41_cal_pkg;
    localparam int TAP_W = 5;
    localparam logic INC = 1'b1;
    localparam logic DEC = 1'b0;
    typedef enum logic [2:0] {IDLE, REWIND, SETTLE, SAMPLE, EVAL, CENTER, DONE} cal_state_e;
endpackage

// File: rtl/ads41_delay_cal_if.sv
// ads41_delay_cal_if: IDELAY control bus and captured data word between calibrator and channel receiver
interface ads41_delay_cal_if #(parameter int NBITS = 12);
    logic [15:0]      idelay_ctrl;
    logic [31:0]      idelay_val;
    logic [NBITS-1:0] d_in;
    modport master (output idelay_ctrl, idelay_val, input d_in);
    modport slave  (input idelay_ctrl, idelay_val, output d_in);
endinterface

// File: rtl/ads41_cal_lane_eye.sv
// ads41_cal_lane_eye: per-lane mismatch capture, widest passing run search and centre tap; optional pass bitmap under ADS41_CAL_BITMAP_EN
module ads41_cal_lane_eye
    import ads41_cal_pkg::*;
#(
    parameter int TAPS         = 32,
    parameter int IDELAY_VALUE = 8,
    parameter int MIN_EYE      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             sample_en,
    input  logic             eval_en,
    input  logic [TAP_W-1:0] tap,
    input  logic [1:0]       d,
    input  logic [1:0]       p,
    output logic [TAP_W-1:0] target,
    output logic             fail,
    output logic [TAPS-1:0]  bitmap
);
    localparam int LW = $clog2(TAPS + 1);

    logic             mism;
    logic [LW-1:0]    run_len, best_len, nxt_len;
    logic [TAP_W-1:0] run_start, best_start, nxt_start, half;

    // run that would result from closing the current tap
    always_comb begin
        nxt_len   = mism ? '0 : run_len + LW'(1);
        nxt_start = (run_len == '0) ? tap : run_start;
        half      = TAP_W'((best_len - LW'(1)) >> 1);
        fail      = best_len < LW'(MIN_EYE);
        target    = fail ? TAP_W'(IDELAY_VALUE) : best_start + half;
    end

    // sticky mismatch per tap, then run/best bookkeeping once per tap; strict > keeps the earliest equal window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            mism       <= 1'b0;
            run_len    <= '0;
            run_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
        end else begin
            if (sample_en && d != p) mism <= 1'b1;
            if (eval_en) begin
                mism      <= 1'b0;
                run_len   <= nxt_len;
                run_start <= nxt_start;
                if (nxt_len > best_len) begin
                    best_len   <= nxt_len;
                    best_start <= nxt_start;
                end
            end
        end
    end

`ifdef ADS41_CAL_BITMAP_EN
    logic [TAPS-1:0] bm;
    // record each passing tap for debug visibility of the eye
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                bm      <= '0;
        else if (clr)              bm      <= '0;
        else if (eval_en && !mism) bm[tap] <= 1'b1;
    end
    assign bitmap = bm;
`else
    assign bitmap = '0;
`endif
endmodule

// File: rtl/ads41_delay_cal.sv
// ads41_delay_cal: IDELAY eye-training controller for one ADS41 channel; cal_bitmap storage enabled by ADS41_CAL_BITMAP_EN
module ads41_delay_cal
    import ads41_cal_pkg::*;
#(
    parameter int NBITS         = 12,
    parameter int TAPS          = 32,
    parameter int IDELAY_VALUE  = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLES       = 64,
    parameter int MIN_EYE       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cal_start,
    input  logic [NBITS-1:0]             pattern,
    ads41_delay_cal_if.master            dly,
    output logic                         cal_busy,
    output logic                         cal_done,
    output logic [NBITS/2-1:0]           cal_fail,
    output logic [NBITS/2*TAP_W-1:0]     lane_tap,
    output logic [NBITS/2*TAPS-1:0]      cal_bitmap
);
    localparam int NL = NBITS / 2;
    localparam int CW = $clog2((SAMPLES > SETTLE_CYCLES ? SAMPLES : SETTLE_CYCLES) + 1);

    cal_state_e       state;
    logic             ph, start_q;
    logic [CW-1:0]    cnt;
    logic [NL-1:0]    ctrl_q, val_q, rew_mask, ctr_mask, lane_fail;
    logic [TAP_W-1:0] trk [NL];
    logic [TAP_W-1:0] tgt [NL];
    logic             rise, clr, sample_en, eval_en;

    assign rise      = cal_start && !start_q;
    assign clr       = state == IDLE && rise;
    assign sample_en = state == SAMPLE;
    assign eval_en   = state == EVAL;
    assign dly.idelay_ctrl = 16'(ctrl_q);
    assign dly.idelay_val  = 32'(val_q);

    // lanes still needing a decrement while rewinding or centring
    always_comb begin
        rew_mask = '0;
        ctr_mask = '0;
        for (int i = 0; i < NL; i++) begin
            rew_mask[i] = trk[i] != '0;
            ctr_mask[i] = trk[i] > tgt[i];
        end
    end

    for (genvar i = 0; i < NL; i++) begin : g_lane
        ads41_cal_lane_eye #(
            .TAPS(TAPS), .IDELAY_VALUE(IDELAY_VALUE), .MIN_EYE(MIN_EYE)
        ) u_eye (
            .clk(clk), .rst_n(rst_n), .clr(clr), .sample_en(sample_en), .eval_en(eval_en),
            .tap(trk[0]), .d(dly.d_in[2*i +: 2]), .p(pattern[2*i +: 2]),
            .target(tgt[i]), .fail(lane_fail[i]), .bitmap(cal_bitmap[i*TAPS +: TAPS])
        );
    end

    // calibration sequencer; a step is ctrl-high for one cycle then ctrl-low (ph) with trackers moved
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ph       <= 1'b0;
            start_q  <= 1'b0;
            cnt      <= '0;
            ctrl_q   <= '0;
            val_q    <= '0;
            cal_busy <= 1'b0;
            cal_done <= 1'b0;
            cal_fail <= '0;
            for (int i = 0; i < NL; i++) begin
                trk[i]                     <= TAP_W'(IDELAY_VALUE);
                lane_tap[i*TAP_W +: TAP_W] <= TAP_W'(IDELAY_VALUE);
            end
        end else begin
            start_q <= cal_start;
            if (ph) begin
                ph     <= 1'b0;
                ctrl_q <= '0;
                for (int i = 0; i < NL; i++)
                    if (ctrl_q[i]) trk[i] <= val_q[i] ? trk[i] + TAP_W'(1) : trk[i] - TAP_W'(1);
            end
            case (state)
                IDLE: if (rise) begin
                    state    <= REWIND;
                    cal_busy <= 1'b1;
                    cal_done <= 1'b0;
                    cal_fail <= '0;
                end
                REWIND: if (!ph) begin
                    if (rew_mask == '0) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end else begin
                        ctrl_q <= rew_mask;
                        val_q  <= {NL{DEC}};
                        ph     <= 1'b1;
                    end
                end
                SETTLE: if (!ph) begin
                    cnt <= (cnt == CW'(SETTLE_CYCLES - 1)) ? '0 : cnt + CW'(1);
                    if (cnt == CW'(SETTLE_CYCLES - 1)) state <= SAMPLE;
                end
                SAMPLE: begin
                    cnt <= (cnt == CW'(SAMPLES - 1)) ? '0 : cnt + CW'(1);
                    if (cnt == CW'(SAMPLES - 1)) state <= EVAL;
                end
                EVAL: begin
                    if (trk[0] == TAP_W'(TAPS - 1)) begin
                        state <= CENTER;
                    end else begin
                        state  <= SETTLE;
                        cnt    <= '0;
                        ctrl_q <= '1;
                        val_q  <= {NL{INC}};
                        ph     <= 1'b1;
                    end
                end
                CENTER: begin
                    cal_fail <= lane_fail;
                    if (!ph) begin
                        if (ctr_mask == '0) begin
                            state <= DONE;
                        end else begin
                            ctrl_q <= ctr_mask;
                            val_q  <= {NL{DEC}};
                            ph     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    cal_busy <= 1'b0;
                    cal_done <= 1'b1;
                    for (int i = 0; i < NL; i++) lane_tap[i*TAP_W +: TAP_W] <= trk[i];
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ads41_delay_cal.sv
// tb_ads41_delay_cal: receiver/eye model driving the calibrator, checked against a brute-force eye-centre reference
module tb_ads41_delay_cal;
    localparam int NBITS = 12;
    localparam int NL    = 6;

    logic              clk = 1'b0, rst_n = 1'b0, cal_start = 1'b0;
    logic [NBITS-1:0]  pattern;
    logic              cal_busy, cal_done;
    logic [NL-1:0]     cal_fail;
    logic [NL*5-1:0]   lane_tap;
    logic [NL*32-1:0]  cal_bitmap;

    int          tests = 0, fails = 0;
    logic [31:0] pass_map [NL];
    int          rx_tap [NL];
    logic [5:0]  prev_ctrl = '0;
    logic [6:0]  moves [$];
    bit          log_moves = 0;

    ads41_delay_cal_if #(.NBITS(NBITS)) dly();

    ads41_delay_cal #(.NBITS(NBITS)) dut (
        .clk(clk), .rst_n(rst_n), .cal_start(cal_start), .pattern(pattern), .dly(dly),
        .cal_busy(cal_busy), .cal_done(cal_done), .cal_fail(cal_fail),
        .lane_tap(lane_tap), .cal_bitmap(cal_bitmap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] win(input int a, input int b);
        logic [31:0] m = '0;
        for (int t = a; t <= b; t++) m[t] = 1'b1;
        return m;
    endfunction

    // {fail, tap}: longest contiguous passing run (earliest on tie), centre rounded down
    function automatic logic [5:0] ref_tap(input logic [31:0] m);
        int bl = 0, bs = 0;
        for (int s = 0; s < 32; s++) begin
            int l = 0;
            while (s + l < 32 && m[s+l]) l++;
            if (l > bl) begin bl = l; bs = s; end
        end
        return (bl < 4) ? {1'b1, 5'd8} : {1'b0, 5'(bs + (bl - 1) / 2)};
    endfunction

    // receiver model: edge-detected CE moves the tap, data word is clean only inside the lane's eye
    initial begin
        dly.d_in = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < NL; i++) rx_tap[i] = 8;
                prev_ctrl = '0;
            end else begin
                tests++;
                assert (dly.idelay_ctrl[15:6] == '0 && dly.idelay_val[31:6] == '0 &&
                        !(dly.idelay_ctrl[5:0] != '0 && prev_ctrl != '0)) else begin
                    fails++;
                    $error("FAIL bus_rules: ctrl %h val %h prev_ctrl %h", dly.idelay_ctrl, dly.idelay_val, prev_ctrl);
                end
                if (log_moves && dly.idelay_ctrl[5:0] != '0 && prev_ctrl == '0)
                    moves.push_back({dly.idelay_val[0], dly.idelay_ctrl[5:0]});
                for (int i = 0; i < NL; i++)
                    if (dly.idelay_ctrl[i] && !prev_ctrl[i])
                        rx_tap[i] = (rx_tap[i] + (dly.idelay_val[i] ? 1 : 31)) % 32;
                prev_ctrl = dly.idelay_ctrl[5:0];
            end
            for (int i = 0; i < NL; i++)
                dly.d_in[2*i +: 2] = pattern[2*i +: 2] ^ (pass_map[i][rx_tap[i]] ? 2'b00 : 2'($urandom_range(0, 3)));
        end
    end

    task automatic run_cal(input string tag);
        int n = 0;
        logic [5:0] e;
        pattern = 12'($urandom);
        @(negedge clk) cal_start = 1'b1;
        @(negedge clk) cal_start = 1'b0;
        chk({tag, "_busy_on_start"}, 32'(cal_busy), 1);
        chk({tag, "_done_cleared"}, 32'(cal_done), 0);
        while (!cal_done && n < 6000) begin
            @(negedge clk);
            n++;
            cal_start = (n == 100 || n == 1500);
        end
        cal_start = 1'b0;
        chk({tag, "_timeout"}, 32'(n < 6000), 1);
        chk({tag, "_busy_end"}, 32'(cal_busy), 0);
        for (int i = 0; i < NL; i++) begin
            e = ref_tap(pass_map[i]);
            chk($sformatf("%s_tap%0d", tag, i), 32'(lane_tap[i*5 +: 5]), 32'(e[4:0]));
            chk($sformatf("%s_fail%0d", tag, i), 32'(cal_fail[i]), 32'(e[5]));
            chk($sformatf("%s_rxtap%0d", tag, i), rx_tap[i], 32'(e[4:0]));
`ifdef ADS41_CAL_BITMAP_EN
            chk($sformatf("%s_bitmap%0d", tag, i), cal_bitmap[i*32 +: 32], pass_map[i]);
`else
            chk($sformatf("%s_bitmap%0d", tag, i), cal_bitmap[i*32 +: 32], 32'h0);
`endif
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 32'(cal_busy), 0);
        chk({tag, "_done"}, 32'(cal_done), 0);
        chk({tag, "_fail"}, 32'(cal_fail), 0);
        chk({tag, "_ctrl"}, 32'(dly.idelay_ctrl), 0);
        chk({tag, "_val"}, dly.idelay_val, 0);
        chk({tag, "_bitmap"}, 32'(|cal_bitmap), 0);
        for (int i = 0; i < NL; i++) chk($sformatf("%s_tap%0d", tag, i), 32'(lane_tap[i*5 +: 5]), 8);
    endtask

    initial begin
        int bad, n, s, l;
        pattern = '0;
        for (int i = 0; i < NL; i++) pass_map[i] = '0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_state("post_reset");

        for (int i = 0; i < NL; i++) pass_map[i] = win(10, 19);
        moves.delete();
        log_moves = 1;
        run_cal("eye10_19");
        log_moves = 0;
        chk("eye10_19_lane0_tap", 32'(lane_tap[4:0]), 14);
        chk("move_count", moves.size(), 56);
        bad = 0;
        foreach (moves[k]) if (moves[k] !== ((k >= 8 && k < 39) ? 7'h7F : 7'h3F)) bad++;
        chk("move_sequence_bad", bad, 0);

        pass_map[0] = win(3, 5);
        pass_map[1] = win(20, 31);
        for (int i = 2; i < NL; i++) pass_map[i] = win(0, 31);
        run_cal("split");
        chk("split_lane1_tap", 32'(lane_tap[9:5]), 25);
        chk("split_lane0_fail", 32'(cal_fail[0]), 1);

        for (int i = 0; i < NL; i++) pass_map[i] = win(10, 19);
        pass_map[2] = win(2, 7) | win(20, 25);
        run_cal("equal_windows");
        chk("equal_windows_lane2_tap", 32'(lane_tap[14:10]), 4);

        for (int i = 0; i < NL; i++) pass_map[i] = win(10, 19);
        @(negedge clk) cal_start = 1'b1;
        @(negedge clk) cal_start = 1'b0;
        n = 0;
        while (rx_tap[0] != 12 && n < 4000) begin @(negedge clk); n++; end
        chk("reach_tap12", 32'(n < 4000), 1);
        repeat (26) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_state("async_reset");
        @(posedge clk) #1 chk_reset_state("reset_edge");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_cal("after_reset");

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NL; i++) begin
                s = $urandom_range(0, 31);
                l = $urandom_range(1, 16);
                pass_map[i] = win(s, (s + l - 1 > 31) ? 31 : s + l - 1);
                if ($urandom_range(0, 1) == 1) begin
                    s = $urandom_range(0, 31);
                    l = $urandom_range(1, 16);
                    pass_map[i] |= win(s, (s + l - 1 > 31) ? 31 : s + l - 1);
                end
            end
            run_cal($sformatf("random%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ads41_delay_cal.md
Name: ads41_delay_cal

Overview:
- Automatic IDELAY eye-training controller for one ADS41 ADC channel; drives the channel's idelay_ctrl/idelay_val bus.
- Sweeps all data-lane taps, checks the captured word against a known ADC test pattern, finds the widest passing window per lane and parks each lane at its centre.
- Sits in the ADC wrapper beside the channel receiver, in the idelay/user clock domain.
- Overrange lane is never moved.

Parameters:
- NBITS, 12, ADC word width; data lanes NL = NBITS/2.
- TAPS, 32, IDELAY tap count; tap width TW = 5.
- IDELAY_VALUE, 8, tap every lane holds after receiver reset; must match the receiver.
- SETTLE_CYCLES, 16, wait after any tap move before sampling (covers FIFO latency).
- SAMPLES, 64, compare cycles per tap.
- MIN_EYE, 4, minimum passing run length for a lane to succeed.

Ports:
- clk  in  1  controller clock; same as receiver idelay_clk and FIFO read clock.
- rst_n  in  1  asynchronous active-low reset.
- cal_start  in  1  rising edge starts calibration; ignored while busy.
- pattern  in  NBITS  expected test-pattern word; static during calibration.
- d_in  in  NBITS  captured word from the receiver (bit 2i+1 rise, 2i fall, lane i).
- idelay_ctrl  out  16  per-lane CE level; receiver edge-detects it.
- idelay_val  out  32  per-lane INC (1 = increment, 0 = decrement).
- cal_busy  out  1  calibration in progress.
- cal_done  out  1  set at end, cleared on next start.
- cal_fail  out  NL  per-lane failure flag (eye < MIN_EYE).
- lane_tap  out  NL*TW  final tap per lane.
- cal_bitmap  out  NL*TAPS  per-lane pass bitmap; see Optional Feature.

Behaviour:
- Reset: all outputs 0, lane_tap = IDELAY_VALUE per lane, FSM IDLE, internal tap trackers = IDELAY_VALUE.
- Step primitive (2 cycles): cycle 0 drives idelay_val with the direction and idelay_ctrl with the lane mask; cycle 1 drives idelay_ctrl = 0 with idelay_val held. There are never two consecutive ctrl-high cycles. Trackers update modulo TAPS at cycle 1.
- idelay_ctrl[15:NL] and idelay_val[31:NL] are always 0; the ovr lane is untouched.
- FSM states and transitions:
  - IDLE: on cal_start rise, go to REWIND; set cal_busy = 1, cal_done = 0, cal_fail = 0; clear eye records.
  - REWIND: decrement all lanes until the tracker reads 0 (IDELAY_VALUE steps; 0 steps if IDELAY_VALUE = 0), then go to SETTLE.
  - SETTLE: count SETTLE_CYCLES, then go to SAMPLE.
  - SAMPLE: for SAMPLES cycles, lane i fails the tap if d_in[2i+1:2i] != pattern[2i+1:2i] on any cycle. Then go to EVAL.
  - EVAL (1 cycle): update per-lane run logic. On pass: run_len += 1, and run_start = tap if run_len was 0. On fail: run_len = 0. If run_len > best_len, record best_len and best_start (strictly greater, so the earliest equal-length window wins). If tap == TAPS-1, go to CENTER; else increment all lanes and go to SETTLE.
  - CENTER: target_i = best_start_i + (best_len_i - 1)/2 (floor). If best_len_i < MIN_EYE, target_i = IDELAY_VALUE and cal_fail[i] = 1. All lanes start at TAPS-1. Repeatedly decrement, masked to lanes with tracker > target, until all lanes match; then go to DONE.
  - DONE: latch lane_tap = trackers, cal_busy = 0, cal_done = 1; go to IDLE.
- A run that reaches tap TAPS-1 closes there; there is no wrap-around joining.
- cal_start while busy: ignored.
- rst_n asserted mid-run: controller returns to reset state immediately. Tap trackers are then invalid until the receiver is also reset (its LD restores IDELAY_VALUE); system reset covers both.
- Latency: (IDELAY_VALUE + TAPS - 1 + max moves)*2 + TAPS*(SETTLE_CYCLES + SAMPLES + 1) + small constant.

Optional Feature:
- ADS41_CAL_BITMAP_EN defined: per-lane TAPS-bit pass bitmap register. It is cleared on start, bit t is set in EVAL on pass, and it drives cal_bitmap.
- Not defined: no bitmap storage; cal_bitmap tied 0. Eye search is unaffected either way.

Decomposition:
- Package ads41_cal_pkg holds:
  - FSM state enum (IDLE, REWIND, SETTLE, SAMPLE, EVAL, CENTER, DONE);
  - TAP_W = 5;
  - step-direction constants INC = 1, DEC = 0.
- Sub-module ads41_cal_lane_eye, instantiated NL times, holds per-lane mismatch accumulation, run_len/run_start/best_len/best_start, target computation and the fail flag. The top keeps the FSM, counters, step primitive and trackers.

Test Plan:
- Eye model passes taps 10..19 on all lanes -> targets 14, cal_fail = 0, cal_done = 1, exactly 8 decrements then 31 increments, then 17 masked decrements.
- Lane 0 passes 3..5, lane 1 passes 20..31, others 0..31 -> lane 0 fail with lane_tap 8; lane 1 tap 25; others tap 15.
- Two equal windows on lane 2 (2..7 and 20..25) -> lane 2 tap 4 (earliest wins).
- Check idelay_ctrl is never high on two consecutive cycles; bits 15:6 and val 31:6 stay 0 throughout.
- rst_n low during SAMPLE at tap 12 -> all outputs 0 next edge; a new cal_start after receiver reset completes normally. cal_start pulses while busy are ignored.
- With ADS41_CAL_BITMAP_EN and the model passing 10..19 -> cal_bitmap per lane = 32'h000FFC00. Without the macro -> cal_bitmap = 0.
